// File: rtl/entwurf_integrierter_schaltungen_hadner_pkg.sv
// Shared types and constants for the PWM pulse-width analyzer tile.
// Holds the segment patterns, the counter width and the classification state.
package entwurf_integrierter_schaltungen_hadner_pkg;

  localparam int CNT_W = 16;

  localparam logic [6:0] SEG_H = 7'h76;
  localparam logic [6:0] SEG_L = 7'h38;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  // Output byte: level on bit 7, matching letter on the segments below it.
  function automatic logic [7:0] encode_out(input state_t st);
    return (st == ST_HIGH) ? {1'b1, SEG_H} : {1'b0, SEG_L};
  endfunction

endpackage

// File: rtl/entwurf_integrierter_schaltungen_hadner_pwm_width_meter.sv
// Synchronizes the PWM input, detects its falling edge and counts high time.
// The counter saturates at MAX_COUNTER_VALUE and clears on the falling edge.
module entwurf_integrierter_schaltungen_hadner_pwm_width_meter
  import entwurf_integrierter_schaltungen_hadner_pkg::*;
#(
  parameter int MAX_COUNTER_VALUE = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] width
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNTER_VALUE);

  logic             sync_1;
  logic             pwm_s;
  logic             pwm_d;
  logic [CNT_W-1:0] count;

  assign fall_pulse = pwm_d & ~pwm_s;
  assign width      = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
      count  <= '0;
    end else begin
      sync_1 <= pwm;
      pwm_s  <= sync_1;
      pwm_d  <= pwm_s;
      // fall implies pwm_s = 0, so clearing never races an increment.
      if (fall_pulse) begin
        count <= '0;
      end else if (pwm_s && (count < MAX_CNT)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entwurf_integrierter_schaltungen_hadner.sv
// TinyTapeout-style tile: classifies RC-servo pulse widths as HIGH/LOW with
// hysteresis and shows the result on uo_out[7] and a 7-segment display.
module entwurf_integrierter_schaltungen_hadner
  import entwurf_integrierter_schaltungen_hadner_pkg::*;
#(
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1900,
  parameter int LOW_COUNTER_VALUE  = 1100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(HIGH_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(LOW_COUNTER_VALUE);

  logic             fall_pulse;
  logic [CNT_W-1:0] width;
  state_t           state;
  logic [7:0]       out_bits;
  logic             unused;

  assign unused  = &{1'b0, ena, uio_in, ui_in[6:0]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
  assign uo_out  = out_bits;

  entwurf_integrierter_schaltungen_hadner_pwm_width_meter #(
    .MAX_COUNTER_VALUE(MAX_COUNTER_VALUE)
  ) u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm       (ui_in[7]),
    .fall_pulse(fall_pulse),
    .width     (width)
  );

  // Widths inside [LOW, HIGH] leave the state untouched (hysteresis band).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_LOW;
      out_bits <= encode_out(ST_LOW);
    end else if (fall_pulse) begin
      if (width > HIGH_CNT) begin
        state    <= ST_HIGH;
        out_bits <= encode_out(ST_HIGH);
      end else if (width < LOW_CNT) begin
        state    <= ST_LOW;
        out_bits <= encode_out(ST_LOW);
      end
    end
  end

endmodule

// File: tb/tb_entwurf_integrierter_schaltungen_hadner.sv
// Self-checking bench for the PWM pulse-width analyzer tile.
// A pulse-level reference model predicts the classified output byte.
module tb_entwurf_integrierter_schaltungen_hadner;

  localparam int MAXV  = 2000;
  localparam int HIGHV = 1900;
  localparam int LOWV  = 1100;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run;
  int fails;
  bit model_high;

  entwurf_integrierter_schaltungen_hadner #(MAXV, HIGHV, LOWV) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_out(input bit high);
    return high ? 8'hF6 : 8'h38;
  endfunction

  // Reference classification straight from the pulse-width rules.
  function automatic bit classify(input bit cur, input int n);
    int w;
    w = (n < MAXV) ? n : MAXV;
    if (w > HIGHV) return 1'b1;
    if (w < LOWV)  return 1'b0;
    return cur;
  endfunction

  task automatic noise();
    ena         = 1'($urandom);
    uio_in      = 8'($urandom);
    ui_in[6:0]  = 7'($urandom);
  endtask

  task automatic drive_high(input int n);
    ui_in[7] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      noise();
    end
  endtask

  // Drop the input, check exact latency of the update, then a quiet gap.
  task automatic finish_pulse(input int n, input string tag);
    logic [7:0] prev_exp;
    int gap;
    prev_exp = exp_out(model_high);
    tests_run++;
    if (uo_out !== prev_exp) begin
      fails++;
      $display("FAIL %s_held_high: uo_out=%h expected=%h", tag, uo_out, prev_exp);
    end
    ui_in[7] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (uo_out !== prev_exp) begin
      fails++;
      $display("FAIL %s_early: uo_out=%h expected=%h", tag, uo_out, prev_exp);
    end
    model_high = classify(model_high, n);
    @(negedge clk);
    tests_run++;
    if (uo_out !== exp_out(model_high)) begin
      fails++;
      $display("FAIL %s_result: width=%0d uo_out=%h expected=%h", tag, n, uo_out, exp_out(model_high));
    end
    gap = $urandom_range(20, 3);
    repeat (gap) begin
      @(negedge clk);
      noise();
    end
    tests_run++;
    if (uo_out !== exp_out(model_high)) begin
      fails++;
      $display("FAIL %s_hold: uo_out=%h expected=%h", tag, uo_out, exp_out(model_high));
    end
    $display("[TB] pulse %s width=%0d -> uo_out=%h", tag, n, uo_out);
  endtask

  task automatic run_pulse(input int n, input string tag);
    drive_high(n);
    finish_pulse(n, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (200) begin
      @(negedge clk);
      noise();
    end
    model_high = 1'b0;
    tests_run++;
    if (uo_out !== 8'h38) begin
      fails++;
      $display("FAIL reset_uo_out: uo_out=%h expected=38", uo_out);
    end
    tests_run++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      fails++;
      $display("FAIL reset_uio: uio_out=%h uio_oe=%h expected=00/00", uio_out, uio_oe);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] reset -> uo_out=%h", uo_out);
  endtask

  task automatic test_basic();
    run_pulse(1000, "basic_1000");
    run_pulse(2000, "basic_2000");
    run_pulse(1500, "hyst_1500");
  endtask

  task automatic test_thresholds();
    run_pulse(300,  "to_low_300");
    run_pulse(1900, "thr_1900");
    run_pulse(1901, "thr_1901");
    run_pulse(1100, "thr_1100");
    run_pulse(1099, "thr_1099");
  endtask

  task automatic test_saturation();
    drive_high(66000);
    tests_run++;
    if (dut.u_meter.width !== 16'd2000) begin
      fails++;
      $display("FAIL sat_count: width=%0d expected=2000", dut.u_meter.width);
    end
    finish_pulse(66000, "sat_66000");
  endtask

  task automatic test_reset_mid_pulse();
    drive_high(945);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    model_high = 1'b0;
    tests_run++;
    if (uo_out !== 8'h38) begin
      fails++;
      $display("FAIL midrst_in_reset: uo_out=%h expected=38", uo_out);
    end
    rst_n = 1'b1;
    // Only the part after release counts; the earlier 945 cycles are discarded.
    drive_high(1000);
    finish_pulse(1000, "midrst_rem");
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 5; k++) begin
      case ($urandom_range(3, 0))
        0:       n = $urandom_range(200, 1);
        1:       n = $urandom_range(1105, 1095);
        2:       n = $urandom_range(1905, 1895);
        default: n = $urandom_range(2050, 1995);
      endcase
      run_pulse(n, "random");
    end
  endtask

  initial begin
    tests_run  = 0;
    fails      = 0;
    model_high = 1'b0;
    ena        = 1'b0;
    uio_in     = 8'h00;
    ui_in      = 8'h00;
    rst_n      = 1'b0;
    test_reset();
    test_basic();
    test_thresholds();
    test_saturation();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
